flow_label_table: RTL and testbench

Flow-label store directly downstream of the inference top level, in the `clk` domain. It captures each `{hash2table, inf_res}` result pulse into a direct-mapped table indexed by the low hash bits. It serves 2-cycle lookups from the packet path so later packets of a classified flow can be labelled without re-inference. It also keeps optional update, eviction and drop statistics.

---
 rtl/flow_label_table.sv | 127 ++++++++++++
 tb/tb_flow_label_table.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/flow_label_table.sv
// flow_label_table: direct-mapped flow-label store with pipelined 2-cycle lookups and optional statistics
// Ports: clk, rst (async, active-high); upd_hash/upd_res/upd_valid update strobe from inference;
// lk_hash/lk_valid lookup request; lk_res_valid/lk_hit/lk_res lookup response (2 cycles later);
// init_done after the clear sweep; upd_cnt/evict_cnt/drop_cnt saturating statistics.
// Build option: define FLOW_TABLE_STATS_EN to build the counters and the eviction compare.
module flow_label_table #(
  parameter int HASH_W = 16,
  parameter int ADDR_W = 10,
  parameter int RES_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [HASH_W-1:0] upd_hash,
  input  logic [RES_W-1:0] upd_res,
  input  logic upd_valid,
  input  logic [HASH_W-1:0] lk_hash,
  input  logic lk_valid,
  output logic lk_res_valid,
  output logic lk_hit,
  output logic [RES_W-1:0] lk_res,
  output logic init_done,
  output logic [31:0] upd_cnt,
  output logic [31:0] evict_cnt,
  output logic [31:0] drop_cnt
);
  localparam int TAG_W = HASH_W - ADDR_W;
  localparam int ENT_W = 1 + TAG_W + RES_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t st;
  logic [ADDR_W-1:0] init_cnt;
  logic [ENT_W-1:0] mem [2**ADDR_W];
  logic upd_fire, wr_en, hit;
  logic [ADDR_W-1:0] upd_idx, lk_idx, wr_idx;
  logic [ENT_W-1:0] upd_ent, wr_ent, b_q, s1_fwd_ent, s1_ent, s2_ent;
  logic s1_v, s1_zero, s1_fwd, s2_v;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  assign upd_fire = upd_valid && st == RUN;
  assign upd_idx = upd_hash[ADDR_W-1:0];
  assign lk_idx = lk_hash[ADDR_W-1:0];
  assign upd_ent = {1'b1, upd_hash[HASH_W-1:ADDR_W], upd_res};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= INIT;
      init_cnt <= '0;
      init_done <= 1'b0;
    end else if (st == INIT) begin
      init_cnt <= init_cnt + ADDR_W'(1);
      if (&init_cnt) begin
        st <= RUN;
        init_done <= 1'b1;
      end
    end
  // Port A: clear sweep during INIT, committed updates during RUN
  always_ff @(posedge clk)
    if (st == INIT) mem[init_cnt] <= '0;
    else if (wr_en) mem[wr_idx] <= wr_ent;
  always_ff @(posedge clk) b_q <= mem[lk_idx];
  // Updates sampled on this edge (newest) or still waiting to commit are merged over the
  // RAM read so a lookup sees exactly the updates sampled at or before its own edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v <= 1'b0;
      s1_tag <= '0;
      s1_zero <= 1'b0;
      s1_fwd <= 1'b0;
      s1_fwd_ent <= '0;
      s2_v <= 1'b0;
      s2_tag <= '0;
      s2_ent <= '0;
      lk_res_valid <= 1'b0;
      lk_hit <= 1'b0;
      lk_res <= '0;
    end else begin
      s1_v <= lk_valid;
      s1_tag <= lk_hash[HASH_W-1:ADDR_W];
      s1_zero <= st == INIT;
      s1_fwd <= (upd_fire && upd_idx == lk_idx) || (wr_en && wr_idx == lk_idx);
      s1_fwd_ent <= upd_fire && upd_idx == lk_idx ? upd_ent : wr_ent;
      s2_v <= s1_v;
      s2_tag <= s1_tag;
      s2_ent <= s1_ent;
      lk_res_valid <= s2_v;
      lk_hit <= s2_v && hit;
      lk_res <= s2_v && hit ? s2_ent[RES_W-1:0] : '0;
    end
  assign s1_ent = s1_zero ? '0 : s1_fwd ? s1_fwd_ent : b_q;
  assign hit = s2_ent[ENT_W-1] && s2_ent[RES_W +: TAG_W] == s2_tag;
`ifdef FLOW_TABLE_STATS_EN
  logic u1_v, u1_fwd, evict;
  logic [ADDR_W-1:0] u1_idx;
  logic [ENT_W-1:0] u1_ent, u1_fwd_ent, a_q, u1_old;
  always_ff @(posedge clk) a_q <= mem[upd_idx];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      u1_v <= 1'b0;
      u1_idx <= '0;
      u1_ent <= '0;
      u1_fwd <= 1'b0;
      u1_fwd_ent <= '0;
      upd_cnt <= '0;
      evict_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      u1_v <= upd_fire;
      u1_idx <= upd_idx;
      u1_ent <= upd_ent;
      u1_fwd <= u1_v && u1_idx == upd_idx;
      u1_fwd_ent <= u1_ent;
      if (u1_v && ~&upd_cnt) upd_cnt <= upd_cnt + 32'd1;
      if (u1_v && evict && ~&evict_cnt) evict_cnt <= evict_cnt + 32'd1;
      if (upd_valid && st == INIT && ~&drop_cnt) drop_cnt <= drop_cnt + 32'd1;
    end
  // The port A read misses the entry being committed on the same edge; use it instead.
  assign u1_old = u1_fwd ? u1_fwd_ent : a_q;
  assign evict = u1_old[ENT_W-1] && u1_old[RES_W +: TAG_W] != u1_ent[RES_W +: TAG_W];
  assign wr_en = u1_v;
  assign wr_idx = u1_idx;
  assign wr_ent = u1_ent;
`else
  assign wr_en = upd_fire;
  assign wr_idx = upd_idx;
  assign wr_ent = upd_ent;
  assign upd_cnt = '0;
  assign evict_cnt = '0;
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_flow_label_table.sv
// tb_flow_label_table: scoreboard bench for flow_label_table against a reference table model
module tb_flow_label_table;
`ifdef FLOW_TABLE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int BIG = 32'h7fffffff;
  typedef struct {
    int due;
    logic hit;
    logic [3:0] res;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] upd_hash = '0;
  logic [3:0] upd_res = '0;
  logic upd_valid = 1'b0;
  logic [15:0] lk_hash = '0;
  logic lk_valid = 1'b0;
  logic lk_res_valid, lk_hit, init_done;
  logic [3:0] lk_res;
  logic [31:0] upd_cnt, evict_cnt, drop_cnt;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_at = BIG;
  exp_t q[$];
  bit mv[1024];
  logic [5:0] mt[1024];
  logic [3:0] mr[1024];
  logic [31:0] exp_upd = '0;
  logic [31:0] exp_evict = '0;
  logic [31:0] exp_drop = '0;

  flow_label_table dut (
    .clk(clk),
    .rst(rst),
    .upd_hash(upd_hash),
    .upd_res(upd_res),
    .upd_valid(upd_valid),
    .lk_hash(lk_hash),
    .lk_valid(lk_valid),
    .lk_res_valid(lk_res_valid),
    .lk_hit(lk_hit),
    .lk_res(lk_res),
    .init_done(init_done),
    .upd_cnt(upd_cnt),
    .evict_cnt(evict_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction

  task automatic clear_model();
    foreach (mv[i]) mv[i] = 1'b0;
    exp_upd = '0;
    exp_evict = '0;
    exp_drop = '0;
  endtask

  task automatic check_counters();
    check("upd_cnt", upd_cnt, STATS ? exp_upd : 32'd0);
    check("evict_cnt", evict_cnt, STATS ? exp_evict : 32'd0);
    check("drop_cnt", drop_cnt, STATS ? exp_drop : 32'd0);
  endtask

  task automatic check_all_zero();
    check("rst_lk_res_valid", lk_res_valid, 0);
    check("rst_lk_hit", lk_hit, 0);
    check("rst_lk_res", lk_res, 0);
    check("rst_init_done", init_done, 0);
    check("rst_upd_cnt", upd_cnt, 0);
    check("rst_evict_cnt", evict_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
  endtask

  // Drive one cycle of stimulus; the model is updated before the lookup expectation so a
  // same-edge lookup sees the new entry.
  task automatic step(input bit uv, input logic [15:0] uh, input logic [3:0] ur,
                      input bit lv, input logic [15:0] lh);
    int e;
    logic h;
    exp_t x;
    @(negedge clk);
    e = cyc + 1;
    upd_valid = uv;
    upd_hash = uh;
    upd_res = ur;
    lk_valid = lv;
    lk_hash = lh;
    if (uv && e <= done_at) exp_drop = sat(exp_drop);
    else if (uv) begin
      if (mv[uh[9:0]] && mt[uh[9:0]] != uh[15:10]) exp_evict = sat(exp_evict);
      exp_upd = sat(exp_upd);
      mv[uh[9:0]] = 1'b1;
      mt[uh[9:0]] = uh[15:10];
      mr[uh[9:0]] = ur;
    end
    if (lv) begin
      h = e > done_at && mv[lh[9:0]] && mt[lh[9:0]] == lh[15:10];
      x.due = e + 2;
      x.hit = h;
      x.res = h ? mr[lh[9:0]] : 4'd0;
      q.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 2) == 0,
           {4'd0, 2'($urandom_range(0, 3)), 7'd0, 3'($urandom_range(0, 7))},
           4'($urandom_range(0, 15)), 1'b1,
           {4'd0, 2'($urandom_range(0, 3)), 7'd0, 3'($urandom_range(0, 7))});
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    check("init_done", init_done, !rst && cyc >= done_at);
    if (q.size() != 0 && q[0].due == cyc) begin
      check("lk_res_valid", lk_res_valid, 1);
      check("lk_hit", lk_hit, q[0].hit);
      check("lk_res", lk_res, q[0].res);
      void'(q.pop_front());
    end else check("lk_res_valid_idle", lk_res_valid, 0);
  end

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1 check_all_zero();
    @(negedge clk);
    rst = 1'b0;
    done_at = cyc + 1024;
    step(1'b0, '0, '0, 1'b1, 16'h1234);
    step(1'b1, 16'h0A05, 4'd9, 1'b0, '0);
    idle(1030);
    check_counters();
    step(1'b1, 16'h0A05, 4'd3, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 16'h0A05);
    step(1'b0, '0, '0, 1'b1, 16'h0E05);
    idle(3);
    step(1'b1, 16'h0405, 4'd1, 1'b0, '0);
    step(1'b1, 16'h0805, 4'd2, 1'b0, '0);
    idle(3);
    check_counters();
    step(1'b0, '0, '0, 1'b1, 16'h0405);
    step(1'b0, '0, '0, 1'b1, 16'h0805);
    step(1'b1, 16'h0805, 4'd7, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 16'h0805);
    idle(3);
    check_counters();
    step(1'b1, 16'h0C10, 4'd5, 1'b1, 16'h0C10);
    step(1'b1, 16'h0010, 4'd1, 1'b0, '0);
    step(1'b1, 16'h0410, 4'd2, 1'b1, 16'h0410);
    step(1'b0, '0, '0, 1'b1, 16'h0410);
    step(1'b0, '0, '0, 1'b1, 16'h0010);
    idle(3);
    check_counters();
    stream(600);
    #2 rst = 1'b1;
    upd_valid = 1'b0;
    lk_valid = 1'b0;
    q.delete();
    clear_model();
    done_at = BIG;
    #1 check_all_zero();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    done_at = cyc + 1024;
    idle(1030);
    check_counters();
    stream(400);
    idle(4);
    check_counters();
`ifdef FLOW_TABLE_STATS_EN
    @(negedge clk);
    force dut.upd_cnt = 32'hFFFFFFFE;
    #1 release dut.upd_cnt;
    exp_upd = 32'hFFFFFFFE;
    step(1'b1, 16'h0123, 4'd1, 1'b0, '0);
    step(1'b1, 16'h0124, 4'd2, 1'b0, '0);
    step(1'b1, 16'h0125, 4'd3, 1'b0, '0);
    idle(3);
    check("upd_cnt_sat", upd_cnt, 32'hFFFFFFFF);
    check_counters();
`endif
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
